// File: rtl/t03_nes_pkg.sv
// t03_nes_pkg: shared state encoding and default timing for the NES controller poller.
package t03_nes_pkg;

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE, WAIT} nes_state_t;

    localparam int NES_LATCH_CYC = 120;
    localparam int NES_HALF_CYC  = 60;
    localparam int NES_POLL_CYC  = 166667;
    localparam int NES_BITS      = 8;

    function automatic int nes_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nes_poll_ctrl_sync2.sv
// sync2: two-flop synchroniser for a single asynchronous input bit.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/nes_poll_ctrl.sv
// nes_poll_ctrl: NES controller port timing master; latches the pad, clocks out 8 bits
// and strobes each synchronised bit plus a frame-complete pulse to the shift register.
module nes_poll_ctrl
    import t03_nes_pkg::*;
#(
    parameter int LATCH_CYC = NES_LATCH_CYC,
    parameter int HALF_CYC  = NES_HALF_CYC,
    parameter int POLL_CYC  = NES_POLL_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic data_in,
    output logic nes_latch,
    output logic nes_pulse,
    output logic data_sync,
    output logic button_en,
    output logic finished,
    output logic busy
);

    localparam int PH_W = $clog2(nes_max(LATCH_CYC, HALF_CYC));
    localparam int PT_W = $clog2(POLL_CYC);
    localparam logic [PH_W-1:0] LATCH_END = PH_W'(LATCH_CYC - 1);
    localparam logic [PH_W-1:0] HALF_END  = PH_W'(HALF_CYC - 1);
    localparam logic [PT_W-1:0] POLL_END  = PT_W'(POLL_CYC - 1);
    localparam logic [2:0]      LAST_BIT  = 3'(NES_BITS - 1);

    if (POLL_CYC <= LATCH_CYC + 15 * HALF_CYC + 1 || LATCH_CYC < 2 || HALF_CYC < 3) begin : g_bad_params
        $error("nes_poll_ctrl: illegal timing parameters");
    end

    nes_state_t      state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [PT_W-1:0] timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic            nes_latch_q, nes_latch_d;
    logic            nes_pulse_q, nes_pulse_d;
    logic            button_en_q, button_en_d;
    logic            finished_q, finished_d;
    logic            busy_q, busy_d;
    logic            frame_start;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (data_in),
        .q   (data_sync)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = LATCH;
            LATCH:   if (phase_q == LATCH_END) state_d = LOW;
            LOW:     if (phase_q == HALF_END) state_d = (bit_q == LAST_BIT) ? DONE : HIGH;
            HIGH: begin
                if (phase_q == HALF_END) begin
                    state_d = LOW;
                    bit_d   = bit_q + 3'd1;
                end
            end
            DONE:    state_d = enable ? WAIT : IDLE;
            WAIT:    state_d = !enable ? IDLE : (timer_q == POLL_END) ? LATCH : WAIT;
            default: state_d = IDLE;
        endcase
        frame_start = (state_d == LATCH) && (state_q != LATCH);
        if (frame_start) bit_d = '0;
        phase_d = (state_d != state_q) ? '0 : phase_q + 1'b1;
        // Poll period is measured from the first LATCH cycle and parks at its end while idle.
        timer_d = frame_start ? '0 : (timer_q == POLL_END) ? timer_q : timer_q + 1'b1;
        // Outputs are decoded from next-state values so they can be registered without lag.
        nes_latch_d = (state_d == LATCH);
        nes_pulse_d = (state_d == HIGH);
        button_en_d = (state_d == LOW) && (phase_d == HALF_END);
        finished_d  = (state_d == DONE);
        busy_d      = state_d inside {LATCH, LOW, HIGH, DONE};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            timer_q     <= '0;
            bit_q       <= '0;
            nes_latch_q <= 1'b0;
            nes_pulse_q <= 1'b0;
            button_en_q <= 1'b0;
            finished_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            timer_q     <= timer_d;
            bit_q       <= bit_d;
            nes_latch_q <= nes_latch_d;
            nes_pulse_q <= nes_pulse_d;
            button_en_q <= button_en_d;
            finished_q  <= finished_d;
            busy_q      <= busy_d;
        end
    end

    assign nes_latch = nes_latch_q;
    assign nes_pulse = nes_pulse_q;
    assign button_en = button_en_q;
    assign finished  = finished_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nes_poll_ctrl.sv
// tb_nes_poll_ctrl: directed bench with a behavioural pad and shift-register model.
module tb_nes_poll_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic data_in;
    logic nes_latch, nes_pulse, data_sync, button_en, finished, busy;

    logic       man_en = 1'b0;
    logic       man_val = 1'b1;
    logic [7:0] sr = 8'hFF;
    logic [7:0] ctrl_byte = 8'hFF;
    logic [7:0] cap = 8'h00;
    logic       lat_p = 1'b0;
    logic       pul_p = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         busy_cnt = 0;
    int         lat_cnt = 0;
    int         ovl = 0;
    int         latch_q[$], pulse_q[$], be_q[$], fin_q[$];
    logic [7:0] out_q[$];

    always #5 clk = ~clk;

    nes_poll_ctrl #(.LATCH_CYC(4), .HALF_CYC(3), .POLL_CYC(60)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .data_in   (data_in),
        .nes_latch (nes_latch),
        .nes_pulse (nes_pulse),
        .data_sync (data_sync),
        .button_en (button_en),
        .finished  (finished),
        .busy      (busy)
    );

    // Pad model: parallel load while latched, shift on each rising clock line, MSB first.
    assign data_in = man_en ? man_val : sr[7];

    always @(posedge nes_latch or posedge nes_pulse) begin
        if (nes_latch) sr <= ctrl_byte;
        else begin
            #3;
            sr <= sr << 1;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (button_en) cap <= {cap[6:0], data_sync};
        if (finished) out_q.push_back(cap);
    end

    always @(negedge clk) begin
        if (nes_latch && !lat_p) latch_q.push_back(cyc);
        if (nes_pulse && !pul_p) pulse_q.push_back(cyc);
        if (button_en) be_q.push_back(cyc);
        if (finished) fin_q.push_back(cyc);
        busy_cnt <= busy_cnt + int'(busy);
        lat_cnt  <= lat_cnt + int'(nes_latch);
        ovl      <= ovl + int'(nes_latch && nes_pulse) + int'(button_en && finished);
        lat_p    <= nes_latch;
        pul_p    <= nes_pulse;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1000;
    endfunction

    function automatic int cnt_in(input int q[$], input int lo, input int hi);
        int n = 0;
        foreach (q[i]) if (q[i] >= lo && q[i] < hi) n++;
        return n;
    endfunction

    function automatic logic [31:0] byte_at(input int i);
        return (i < out_q.size()) ? 32'(out_q[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear();
        latch_q.delete();
        pulse_q.delete();
        be_q.delete();
        fin_q.delete();
        out_q.delete();
    endtask

    task automatic wait_latch(output int t);
        for (int i = 0; i < 50 && latch_q.size() == 0; i++) step();
        chk("latch_seen", latch_q.size(), 1);
        t = at(latch_q, 0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int t0, r, b0, l0;
        step();
        step();
        chk("rst_outs", {nes_latch, nes_pulse, button_en, finished, busy}, 0);
        chk("rst_sync", data_sync, 1);
        rst = 1'b0;
        repeat (100) step();
        chk("idle_latch", latch_q.size(), 0);
        chk("idle_pulse", pulse_q.size(), 0);

        ctrl_byte = 8'hA5;
        clear();
        l0 = lat_cnt;
        r = cyc;
        enable = 1'b1;
        wait_latch(t0);
        chk("start_lat", t0 - r, 1);
        wait_until(t0 + 170);
        enable = 1'b0;
        for (int k = 0; k < 8; k++) chk($sformatf("be%0d", k), at(be_q, k) - t0, 6 + 6 * k);
        chk("fin0", at(fin_q, 0) - t0, 49);
        chk("be_cnt", be_q.size(), 24);
        chk("fin_cnt", fin_q.size(), 3);
        chk("lat_hi", lat_cnt - l0, 12);
        chk("lat1", at(latch_q, 1) - t0, 60);
        chk("lat2", at(latch_q, 2) - t0, 120);
        chk("pul_f0", cnt_in(pulse_q, t0, t0 + 60), 7);
        chk("pul_f1", cnt_in(pulse_q, t0 + 60, t0 + 120), 7);
        chk("pul_f2", cnt_in(pulse_q, t0 + 120, t0 + 180), 7);
        chk("byte_a5_0", byte_at(0), 8'hA5);
        chk("byte_a5_2", byte_at(2), 8'hA5);
        repeat (80) step();
        chk("stop_lat", latch_q.size(), 3);

        ctrl_byte = 8'h3C;
        clear();
        b0 = busy_cnt;
        enable = 1'b1;
        wait_latch(t0);
        wait_until(t0 + 20);
        enable = 1'b0;
        wait_until(t0 + 120);
        chk("dis_fin_cnt", fin_q.size(), 1);
        chk("dis_fin", at(fin_q, 0) - t0, 49);
        chk("dis_be_cnt", be_q.size(), 8);
        chk("dis_lat_cnt", latch_q.size(), 1);
        chk("dis_busy", busy_cnt - b0, 50);
        chk("dis_byte", byte_at(0), 8'h3C);

        ctrl_byte = 8'h96;
        clear();
        enable = 1'b1;
        wait_latch(t0);
        wait_until(t0 + 30);
        rst = 1'b1;
        #1;
        chk("rst5_outs", {nes_latch, nes_pulse, button_en, finished, busy}, 0);
        chk("rst5_sync", data_sync, 1);
        step();
        step();
        chk("rst5_nofin", fin_q.size(), 0);
        clear();
        r = cyc;
        rst = 1'b0;
        wait_latch(t0);
        chk("rst5_lat", t0 - r, 1);
        wait_until(t0 + 55);
        enable = 1'b0;
        chk("rst5_fin_cnt", fin_q.size(), 1);
        chk("rst5_fin", at(fin_q, 0) - t0, 49);
        chk("rst5_byte", byte_at(0), 8'h96);

        repeat (10) step();
        man_en = 1'b1;
        man_val = 1'b1;
        repeat (3) step();
        #2 man_val = 1'b0;
        step();
        chk("sync_hold0", data_sync, 1);
        step();
        chk("sync_fall", data_sync, 0);
        #2 man_val = 1'b1;
        step();
        chk("sync_hold1", data_sync, 0);
        step();
        chk("sync_rise", data_sync, 1);
        man_en = 1'b0;

        ctrl_byte = 8'h00;
        clear();
        enable = 1'b1;
        wait_latch(t0);
        enable = 1'b0;
        wait_until(t0 + 60);
        chk("byte_00", byte_at(0), 8'h00);
        ctrl_byte = 8'hFF;
        clear();
        enable = 1'b1;
        wait_latch(t0);
        enable = 1'b0;
        wait_until(t0 + 60);
        chk("byte_ff", byte_at(0), 8'hFF);
        chk("overlap", ovl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
